// File: rtl/stereolbm_mul_arbiter.sv
// Four-requester front end for one shared unsigned multiplier: round-robin issue,
// a single issue register, and a held result slot per requester until it is consumed.
`timescale 1ns/1ps
module stereolbm_mul_arbiter #(
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 10,
  parameter int P_WIDTH = 15,
  parameter int NREQ    = 4
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*A_WIDTH-1:0]    req_a,
  input  logic [NREQ*B_WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [NREQ*P_WIDTH-1:0]    rsp_p,
  output logic                       busy,
  output logic [15:0]                issue_count
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;

  logic [NREQ-1:0]         out_q, out_d;
  logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [NREQ*P_WIDTH-1:0] rsp_p_q, rsp_p_d;
  logic [1:0]              ptr_q, ptr_d;
  logic                    iss_v_q, iss_v_d;
  logic [1:0]              iss_id_q, iss_id_d;
  logic [A_WIDTH-1:0]      iss_a_q, iss_a_d;
  logic [B_WIDTH-1:0]      iss_b_q, iss_b_d;
  logic [15:0]             cnt_q, cnt_d;

  logic [NREQ-1:0]         eligible;
  logic [NREQ-1:0]         grant;
  logic                    grant_vld;
  logic [1:0]              grant_idx;
  logic [M_WIDTH-1:0]      prod;
  logic [P_WIDTH-1:0]      result;

  // Reset gates eligibility so req_ready is quiet while reset is held.
  assign eligible = req_valid & ~out_q & {NREQ{~ap_rst}};

  always_comb begin
    logic [1:0] idx;
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    grant     = '0;
    idx       = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    grant[grant_idx] = grant_vld;
  end

  assign prod   = M_WIDTH'(iss_a_q) * M_WIDTH'(iss_b_q);
  assign result = P_WIDTH'(prod);

  always_comb begin
    out_d       = (out_q & ~(rsp_valid_q & rsp_ready)) | grant;
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_p_d     = rsp_p_q;
    if (iss_v_q) begin
      rsp_valid_d[iss_id_q]                   = 1'b1;
      rsp_p_d[iss_id_q*P_WIDTH +: P_WIDTH]    = result;
    end
    iss_v_d  = grant_vld;
    iss_id_d = grant_idx;
    iss_a_d  = req_a[grant_idx*A_WIDTH +: A_WIDTH];
    iss_b_d  = req_b[grant_idx*B_WIDTH +: B_WIDTH];
    ptr_d    = grant_vld ? grant_idx + 2'd1 : ptr_q;
    cnt_d    = cnt_q + {15'd0, grant_vld};
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_q       <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      ptr_q       <= '0;
      iss_v_q     <= 1'b0;
      iss_id_q    <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      ptr_q       <= ptr_d;
      iss_v_q     <= iss_v_d;
      iss_id_q    <= iss_id_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready   = grant;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_p       = rsp_p_q;
  assign busy        = |out_q;
  assign issue_count = cnt_q;

endmodule
